// File: rtl/im_loader.sv
// Instruction memory loader: takes a byte stream (address, count, data words, checksum),
// writes big-endian words into the instruction memory and releases the CPU once the checksum is good.
module im_loader #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 32,
  parameter int unsigned MAX_WORDS = 32'h0000_FFFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VLD,
  output logic              BYTE_RDY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [DATA_W-1:0] IM_WDATA,
  output logic              CPU_RST_F,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  // state    | meaning
  // IDLE     | waiting for START, CPU held in reset
  // ADDR_*   | receiving start word address
  // CNT_*    | receiving word count
  // DATA     | assembling a word, MSB first
  // WRITE    | one-cycle memory write of the assembled word
  // CHECK    | waiting for the checksum byte
  // DONE     | load good, CPU released
  // ERROR    | load aborted, CPU held in reset
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
    S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          hi_byte;
  logic [ADDR_W-1:0]   addr;
  logic [15:0]         cnt;
  logic [1:0]          idx;
  logic [7:0]          sum;
  logic [DATA_W-1:0]   word;
  logic                cpu_rst_f;
  logic                xfer;
  logic [7:0]          sum_nxt;
  logic [15:0]         cnt_in;

  assign xfer    = BYTE_VLD && BYTE_RDY;
  assign sum_nxt = sum + BYTE_IN;
  assign cnt_in  = {hi_byte, BYTE_IN};

  always_comb begin
    state_nxt = state;
    BYTE_RDY  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (START) state_nxt = S_ADDR_HI;
      S_ADDR_HI: begin BYTE_RDY = 1'b1; if (xfer) state_nxt = S_ADDR_LO; end
      S_ADDR_LO: begin BYTE_RDY = 1'b1; if (xfer) state_nxt = S_CNT_HI; end
      S_CNT_HI:  begin BYTE_RDY = 1'b1; if (xfer) state_nxt = S_CNT_LO; end
      S_CNT_LO: begin
        BYTE_RDY = 1'b1;
        if (xfer) begin
          if (32'(cnt_in) > MAX_WORDS) state_nxt = S_ERROR;
          else if (cnt_in == 16'd0)    state_nxt = S_CHECK;
          else                         state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        BYTE_RDY = 1'b1;
        if (xfer && idx == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = (cnt == 16'd1) ? S_CHECK : S_DATA;
      S_CHECK: begin
        BYTE_RDY = 1'b1;
        if (xfer) state_nxt = (sum_nxt == 8'd0) ? S_DONE : S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      hi_byte   <= '0;
      addr      <= '0;
      cnt       <= '0;
      idx       <= '0;
      sum       <= '0;
      word      <= '0;
      cpu_rst_f <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_rst_f <= (state_nxt == S_DONE);
      if ((state == S_IDLE || state == S_DONE || state == S_ERROR) && START) begin
        sum <= '0;
        idx <= '0;
      end
      if (xfer) begin
        sum <= sum_nxt;
        case (state)
          S_ADDR_HI, S_CNT_HI: hi_byte <= BYTE_IN;
          S_ADDR_LO:           addr    <= ADDR_W'(cnt_in);
          S_CNT_LO:            cnt     <= cnt_in;
          S_DATA: begin
            word <= {word[DATA_W-9:0], BYTE_IN};
            idx  <= idx + 2'd1;
          end
          default: ;
        endcase
      end
      // address wraps naturally at the top of the word space
      if (state == S_WRITE) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 16'd1;
      end
    end
  end

  assign IM_WE     = (state == S_WRITE);
  assign IM_ADDR   = addr;
  assign IM_WDATA  = word;
  assign CPU_RST_F = cpu_rst_f;
  assign DONE      = (state == S_DONE);
  assign ERR       = (state == S_ERROR);
  assign BUSY      = !(state == S_IDLE || state == S_DONE || state == S_ERROR);

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: streams program images and checks memory writes
// against a scoreboard of expected (address, word) pairs plus status outputs.
module tb_im_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VLD;
  logic        BYTE_RDY;
  logic        IM_WE;
  logic [15:0] IM_ADDR;
  logic [31:0] IM_WDATA;
  logic        CPU_RST_F;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];

  im_loader #(.ADDR_W(16), .DATA_W(32), .MAX_WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VLD(BYTE_VLD),
    .BYTE_RDY(BYTE_RDY), .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_WDATA(IM_WDATA),
    .CPU_RST_F(CPU_RST_F), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (IM_WE === 1'b1) begin
      chk("we_expected", 48'(exp_q.size() != 0), 48'd1);
      if (exp_q.size() != 0) chk("write", {IM_ADDR, IM_WDATA}, exp_q.pop_front());
    end
  end

  // Builds a stream and queues its expected writes; bad=1 corrupts the checksum by +1.
  task automatic build(input logic [15:0] a, input logic [31:0] w[$], input bit bad,
                       output logic [7:0] s[$]);
    logic [7:0]  sum;
    logic [15:0] n;
    n = 16'(w.size());
    s = {a[15:8], a[7:0], n[15:8], n[7:0]};
    foreach (w[k]) begin
      s.push_back(w[k][31:24]); s.push_back(w[k][23:16]);
      s.push_back(w[k][15:8]);  s.push_back(w[k][7:0]);
      exp_q.push_back({16'(a + 16'(k)), w[k]});
    end
    sum = 8'd0;
    foreach (s[k]) sum = sum + s[k];
    s.push_back(8'd0 - sum + 8'(bad));
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    int n;
    n = 0;
    if (stall) begin
      BYTE_VLD = 1'b0; BYTE_IN = 8'h5A;
      @(negedge CLK);
    end
    BYTE_IN = b; BYTE_VLD = 1'b1;
    while (BYTE_RDY !== 1'b1 && n < 64) begin
      @(negedge CLK);
      n++;
    end
    chk("rdy_wait", 48'(n < 64), 48'd1);
    @(negedge CLK);
    BYTE_VLD = 1'b0;
  endtask

  task automatic load(input logic [7:0] s[$], input bit stall);
    int n;
    n = (s.size() >= 4) ? int'({s[2], s[3]}) : 0;
    for (int i = 0; i < s.size(); i++) begin
      send(s[i], stall);
      if (i >= 4 && i < 4 + 4 * n && ((i - 4) % 4) == 3) chk("we_latency", 48'(IM_WE), 48'd1);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic done_e, input logic err_e,
                            input logic cpu_e, input logic busy_e);
    chk({tag, "_done"}, 48'(DONE), 48'(done_e));
    chk({tag, "_err"},  48'(ERR),  48'(err_e));
    chk({tag, "_cpu"},  48'(CPU_RST_F), 48'(cpu_e));
    chk({tag, "_busy"}, 48'(BUSY), 48'(busy_e));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},   48'(BYTE_RDY), 48'd0);
    chk({tag, "_we"},    48'(IM_WE), 48'd0);
    chk({tag, "_addr"},  48'(IM_ADDR), 48'd0);
    chk({tag, "_wdata"}, 48'(IM_WDATA), 48'd0);
    chk_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  s[$];
    logic [31:0] w[$];
    RST = 1'b1; START = 1'b0; BYTE_IN = 8'h00; BYTE_VLD = 1'b0;
    #3;
    chk_reset_vals("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Bytes offered in IDLE must not be consumed.
    BYTE_VLD = 1'b1; BYTE_IN = 8'h77;
    repeat (3) @(negedge CLK);
    chk("idle_rdy", 48'(BYTE_RDY), 48'd0);
    BYTE_VLD = 1'b0;

    // Good single-word load at address 0.
    w = {32'h12345678};
    build(16'h0000, w, 1'b0, s);
    chk("stream_chk_byte", 48'(s[8]), 48'hEB);
    pulse_start();
    load(s, 1'b0);
    chk_status("good1", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("good1_rdy", 48'(BYTE_RDY), 48'd0);
    chk("good1_sb", 48'(exp_q.size()), 48'd0);

    // Restart from DONE, then bad checksum.
    pulse_start();
    chk_status("restart", 1'b0, 1'b0, 1'b0, 1'b1);
    build(16'h0000, w, 1'b1, s);
    load(s, 1'b0);
    chk_status("badchk", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("badchk_sb", 48'(exp_q.size()), 48'd0);

    // Zero count: no writes.
    w = {};
    build(16'h0005, w, 1'b0, s);
    pulse_start();
    load(s, 1'b0);
    chk_status("zero", 1'b1, 1'b0, 1'b1, 1'b0);

    // Two words across the address wrap, unstalled then stalled.
    w = {32'hDEADBEEF, 32'hCAFEF00D};
    build(16'hFFFF, w, 1'b0, s);
    pulse_start();
    load(s, 1'b0);
    chk_status("wrap", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("wrap_sb", 48'(exp_q.size()), 48'd0);
    build(16'hFFFF, w, 1'b0, s);
    pulse_start();
    load(s, 1'b1);
    chk_status("stall", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("stall_sb", 48'(exp_q.size()), 48'd0);

    // Count above the limit aborts right after CNT_LO.
    s = {8'h00, 8'h00, 8'h00, 8'h05};
    pulse_start();
    load(s, 1'b0);
    chk_status("limit", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("limit_rdy", 48'(BYTE_RDY), 48'd0);
    repeat (3) @(negedge CLK);
    chk("limit_hold", 48'(ERR), 48'd1);

    // Reset in the middle of a word discards it.
    pulse_start();
    s = {8'h00, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB};
    load(s, 1'b0);
    chk("midword_busy", 48'(BUSY), 48'd1);
    RST = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge CLK);
    RST = 1'b0;
    BYTE_VLD = 1'b1; BYTE_IN = 8'hCC;
    repeat (4) @(negedge CLK);
    BYTE_VLD = 1'b0;
    chk_reset_vals("post_rst");
    chk("final_sb", 48'(exp_q.size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
